idct_tap_sched: RTL and testbench

Scheduler/controller for the existing 4-tap systolic IDCT column unit (constant taps 64, -36, -64, 83, rounding +2048 then >>>12, registered output). It accepts one 4-sample block per cycle over a valid/ready handshake and drives the unit's four lanes with the required diagonal skew. It tags in-flight results, captures the unit's registered output into a credit-protected output FIFO, and sequences a frame of N blocks with a start/busy/done FSM. The datapath has no enable, so all back-pressure is absorbed here.

---
 rtl/idct_tap_sched_if.sv | 35 +++
 rtl/idct_tap_sched.sv | 170 +++++++++++++++++
 tb/tb_idct_tap_sched.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_tap_sched_if.sv
// Block stream, result stream and datapath lane bundle for idct_tap_sched.
// Ports: in_valid/in_ready/in_x0..3 (block in), out_valid/out_ready/out_data (result out),
//        dp_in_1..4 (to datapath lanes), dp_out (datapath registered result).
interface idct_tap_sched_if #(
  parameter int W = 25
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x0;
  logic signed [W-1:0] in_x1;
  logic signed [W-1:0] in_x2;
  logic signed [W-1:0] in_x3;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;

  logic signed [W-1:0] dp_in_1;
  logic signed [W-1:0] dp_in_2;
  logic signed [W-1:0] dp_in_3;
  logic signed [W-1:0] dp_in_4;
  logic signed [W-1:0] dp_out;

  // Scheduler side
  modport slave (
    input  in_valid, in_x0, in_x1, in_x2, in_x3, out_ready, dp_out,
    output in_ready, out_valid, out_data, dp_in_1, dp_in_2, dp_in_3, dp_in_4
  );

  // Source/sink/datapath side
  modport master (
    output in_valid, in_x0, in_x1, in_x2, in_x3, out_ready, dp_out,
    input  in_ready, out_valid, out_data, dp_in_1, dp_in_2, dp_in_3, dp_in_4
  );
endinterface

// File: rtl/idct_tap_sched.sv
// Scheduler for the 4-tap systolic IDCT column unit: lane skew, result tagging, output FIFO, frame FSM.
// Latency: accept edge E0 -> result pushed at E0+LAT, visible on out_data right after that edge.
// Backpressure: in_ready only while FIFO entries plus in-flight results stay below FIFO_DEPTH.
// Ports: clk, reset (async, active-high), start/cfg_nblocks/busy/done frame control,
//        bus (slave): block in, result out, datapath lanes dp_in_1..4 and dp_out.
module idct_tap_sched #(
  parameter int W          = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int NB_W       = 16,
  parameter int LAT        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NB_W-1:0] cfg_nblocks,
  output logic            busy,
  output logic            done,
  idct_tap_sched_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [NB_W-1:0]     nblocks;
  logic [NB_W-1:0]     accepted;
  logic [NB_W-1:0]     emitted;

  logic                accept;
  logic                push;
  logic                pop;
  logic [LAT-1:0]      tag;
  logic [IW-1:0]       inflight;
  logic [SW-1:0]       occupancy;

  // Skew chains: lane k is k registers deep so sample x(k-1) meets the
  // partial sum travelling down the systolic array.
  logic signed [W-1:0] lane1;
  logic signed [W-1:0] l2_0, lane2;
  logic signed [W-1:0] l3_0, l3_1, lane3;
  logic signed [W-1:0] l4_0, l4_1, l4_2, lane4;

  logic signed [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + IW'(tag[i]);
    end
  end

  // Reserving FIFO space for every in-flight block is what lets the
  // enable-less datapath run freely without ever overflowing the FIFO.
  assign occupancy    = SW'(count) + SW'(inflight);
  assign bus.in_ready = (state == S_RUN) && (occupancy < SW'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  assign push = tag[LAT-1];
  assign pop  = bus.out_ready && (count != '0);

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;

  assign bus.dp_in_1 = lane1;
  assign bus.dp_in_2 = lane2;
  assign bus.dp_in_3 = lane3;
  assign bus.dp_in_4 = lane4;

  // Lane skew and tag pipe; idle cycles inject zeros with a zero tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane1 <= '0;
      l2_0  <= '0;
      lane2 <= '0;
      l3_0  <= '0;
      l3_1  <= '0;
      lane3 <= '0;
      l4_0  <= '0;
      l4_1  <= '0;
      l4_2  <= '0;
      lane4 <= '0;
      tag   <= '0;
    end else begin
      lane1 <= accept ? bus.in_x0 : '0;
      l2_0  <= accept ? bus.in_x1 : '0;
      lane2 <= l2_0;
      l3_0  <= accept ? bus.in_x2 : '0;
      l3_1  <= l3_0;
      lane3 <= l3_1;
      l4_0  <= accept ? bus.in_x3 : '0;
      l4_1  <= l4_0;
      l4_2  <= l4_1;
      lane4 <= l4_2;
      tag   <= {tag[LAT-2:0], accept};
    end
  end

  // FIFO storage carries no reset; out_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.dp_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame FSM with registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      nblocks  <= '0;
      accepted <= '0;
      emitted  <= '0;
    end else begin
      done <= 1'b0;
      if (pop) emitted <= emitted + NB_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            nblocks  <= cfg_nblocks;
            accepted <= '0;
            emitted  <= '0;
            busy     <= 1'b1;
            state    <= (cfg_nblocks == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            accepted <= accepted + NB_W'(1);
            if (accepted + NB_W'(1) == nblocks) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (inflight == '0 && count == '0 && emitted == nblocks) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_tap_sched.sv
// Bench for idct_tap_sched: includes a behavioural 4-tap systolic column unit on the dp lanes
// and a scoreboard queue filled at each accepted block, drained at each consumed result.
module tb_idct_tap_sched;
  localparam int W     = 25;
  localparam int DEPTH = 8;
  localparam int NB_W  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [NB_W-1:0] cfg = '0;
  logic            busy;
  logic            done;

  idct_tap_sched_if #(.W(W)) bus ();

  idct_tap_sched #(.W(W), .FIFO_DEPTH(DEPTH), .NB_W(NB_W), .LAT(5)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_nblocks(cfg),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Column unit: partial sum moves one lane per cycle, registered rounded output.
  logic signed [47:0] a1 = '0, a2 = '0, a3 = '0, dp_r = '0;
  always_ff @(posedge clk) begin
    a1   <= 48'sd64 * bus.dp_in_1;
    a2   <= a1 - 48'sd36 * bus.dp_in_2;
    a3   <= a2 - 48'sd64 * bus.dp_in_3;
    dp_r <= (a3 + 48'sd83 * bus.dp_in_4 + 48'sd2048) >>> 12;
  end
  assign bus.dp_out = dp_r[W-1:0];

  function automatic logic signed [W-1:0] ref_calc(input logic signed [W-1:0] x0, x1, x2, x3);
    logic signed [47:0] s;
    s = 48'sd64 * x0 - 48'sd36 * x1 - 48'sd64 * x2 + 48'sd83 * x3 + 48'sd2048;
    s = s >>> 12;
    return s[W-1:0];
  endfunction

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_pop = 0;
  int n_done = 0;
  int cyc = 0;
  bit acc_ev, pop_ev;
  logic signed [W-1:0] got;
  logic signed [W-1:0] exp_q[$];

  // Advance one clock: handshakes observed at the falling edge, inputs change 1ns after rising edge.
  task automatic step();
    @(negedge clk);
    acc_ev = bus.in_valid && bus.in_ready;
    pop_ev = bus.out_valid && bus.out_ready;
    got    = bus.out_data;
    if (acc_ev) begin
      exp_q.push_back(ref_calc(bus.in_x0, bus.in_x1, bus.in_x2, bus.in_x3));
      n_acc++;
    end
    if (pop_ev) n_pop++;
    @(posedge clk);
    #1;
    cyc++;
    if (done) n_done++;
  endtask

  task automatic new_x();
    bus.in_x0 = W'($urandom);
    bus.in_x1 = W'($urandom);
    bus.in_x2 = W'($urandom);
    bus.in_x3 = W'($urandom);
  endtask

  task automatic start_frame(input int n);
    cfg   = NB_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_x0 = '0; bus.in_x1 = '0; bus.in_x2 = '0; bus.in_x3 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    tests++; if ({bus.dp_in_1, bus.dp_in_2, bus.dp_in_3, bus.dp_in_4} !== '0) begin
      fails++; $display("FAIL reset_dp_in: got %0d %0d %0d %0d want 0", bus.dp_in_1, bus.dp_in_2, bus.dp_in_3, bus.dp_in_4);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single(input string name, input logic signed [W-1:0] x0, x1, x2, x3,
                             input logic signed [W-1:0] want);
    int k;
    logic signed [W-1:0] e;
    bus.out_ready = 1'b0;
    start_frame(1);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready: got %b want 1", name, bus.in_ready); end
    bus.in_x0 = x0; bus.in_x1 = x1; bus.in_x2 = x2; bus.in_x3 = x3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    tests++; if (acc_ev !== 1'b1) begin fails++; $display("FAIL %s_accept: got %b want 1", name, acc_ev); end
    repeat (4) step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_early: out_valid got %b want 0 at E0+4", name, bus.out_valid); end
    step();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency: out_valid got %b want 1 at E0+5", name, bus.out_valid); end
    tests++; if (bus.out_data !== want) begin fails++; $display("FAIL %s_value: got %0d want %0d", name, bus.out_data, want); end
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (!pop_ev || exp_q.size() == 0) begin
      fails++; $display("FAIL %s_pop: pop %b queued %0d want pop with 1 queued", name, pop_ev, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin fails++; $display("FAIL %s_data: got %0d want %0d", name, got, e); end
    end
    k = 0;
    while (!done && k < 6) begin step(); k++; end
    tests++; if (!done || k > 3) begin fails++; $display("FAIL %s_done: seen %b after %0d cycles want within 3", name, done, k); end
    step();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s_idle: done %b busy %b want 0 0", name, done, busy); end
  endtask

  task automatic test_stream();
    int acc, pops, first, last, d0;
    bit ok;
    logic signed [W-1:0] e;
    acc = 0; pops = 0; first = 0; last = 0; ok = 0; d0 = n_done;
    new_x();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    start_frame(20);
    for (int k = 0; k < 200; k++) begin
      step();
      if (acc_ev) begin
        acc++;
        if (acc == 1) first = cyc;
        last = cyc;
        if (acc == 20) bus.in_valid = 1'b0; else new_x();
      end
      if (pop_ev) begin
        pops++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stream_data: unexpected result %0d", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL stream_data: result %0d got %0d want %0d", pops, got, e); end
        end
      end
      if (done) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    tests++; if (!ok) begin fails++; $display("FAIL stream_timeout: done not seen in 200 cycles"); end
    tests++; if (acc != 20) begin fails++; $display("FAIL stream_accepts: got %0d want 20", acc); end
    tests++; if (last - first != 19) begin fails++; $display("FAIL stream_throughput: accept span %0d want 19", last - first); end
    tests++; if (pops != 20) begin fails++; $display("FAIL stream_pops: got %0d want 20", pops); end
    tests++; if (n_done - d0 != 1) begin fails++; $display("FAIL stream_done_once: got %0d pulses want 1", n_done - d0); end
  endtask

  task automatic test_backpressure();
    int acc0, pop0, maxo, pops, d0;
    bit ok;
    logic signed [W-1:0] e;
    acc0 = n_acc; pop0 = n_pop; maxo = 0; pops = 0; ok = 0; d0 = n_done;
    new_x();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    start_frame(20);
    for (int k = 0; k < 30; k++) begin
      step();
      if (acc_ev) new_x();
      if (n_acc - acc0 - (n_pop - pop0) > maxo) maxo = n_acc - acc0 - (n_pop - pop0);
    end
    tests++; if (n_acc - acc0 != DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d want %0d", n_acc - acc0, DEPTH); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (acc_ev) begin
        if (n_acc - acc0 == 20) bus.in_valid = 1'b0; else new_x();
      end
      if (n_acc - acc0 - (n_pop - pop0) > maxo) maxo = n_acc - acc0 - (n_pop - pop0);
      if (pop_ev) begin
        pops++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_data: unexpected result %0d", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL bp_data: result %0d got %0d want %0d", pops, got, e); end
        end
      end
      if (done) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: done not seen in 200 cycles"); end
    tests++; if (maxo > DEPTH) begin fails++; $display("FAIL bp_overflow: outstanding %0d exceeds %0d", maxo, DEPTH); end
    tests++; if (pops != 20) begin fails++; $display("FAIL bp_pops: got %0d want 20", pops); end
    tests++; if (n_done - d0 != 1) begin fails++; $display("FAIL bp_done_once: got %0d pulses want 1", n_done - d0); end
  endtask

  task automatic test_reset_midframe();
    int acc0;
    acc0 = n_acc;
    new_x();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    start_frame(10);
    for (int k = 0; k < 10 && (n_acc - acc0) < 3; k++) begin
      step();
      if (acc_ev) new_x();
    end
    bus.in_valid = 1'b0;
    tests++; if (n_acc - acc0 != 3) begin fails++; $display("FAIL midrst_setup: accepts %0d want 3", n_acc - acc0); end
    reset = 1'b1;
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if ({bus.dp_in_1, bus.dp_in_2, bus.dp_in_3, bus.dp_in_4} !== '0) begin
      fails++; $display("FAIL midrst_dp_in: got %0d %0d %0d %0d want 0", bus.dp_in_1, bus.dp_in_2, bus.dp_in_3, bus.dp_in_4);
    end
    exp_q.delete();
    reset = 1'b0;
    repeat (6) step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_flush: out_valid got %b want 0", bus.out_valid); end
    test_single("after_reset", 25'sd4096, 25'sd4096, 25'sd4096, 25'sd4096, 25'sd47);
  endtask

  task automatic test_empty_and_restart();
    int acc0, k, d0, pops;
    bit ok;
    logic signed [W-1:0] e;
    acc0 = n_acc; d0 = n_done;
    new_x();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    start_frame(0);
    k = 0;
    while (!done && k < 5) begin step(); k++; end
    tests++; if (!done || k > 3) begin fails++; $display("FAIL empty_done: seen %b after %0d cycles want within 3", done, k); end
    step();
    tests++; if (n_acc != acc0) begin fails++; $display("FAIL empty_accepts: got %0d want 0", n_acc - acc0); end
    tests++; if (n_done - d0 != 1) begin fails++; $display("FAIL empty_done_once: got %0d pulses want 1", n_done - d0); end
    // Second start during RUN must not reload the block count.
    acc0 = n_acc; d0 = n_done; pops = 0; ok = 0;
    start_frame(2);
    step();
    if (acc_ev) new_x();
    cfg = NB_W'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    if (acc_ev) new_x();
    if (pop_ev) begin
      pops++;
      tests++;
      e = exp_q.pop_front();
      if (got !== e) begin fails++; $display("FAIL restart_data: got %0d want %0d", got, e); end
    end
    for (int j = 0; j < 100; j++) begin
      step();
      if (acc_ev) new_x();
      if (pop_ev) begin
        pops++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL restart_data: unexpected result %0d", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin fails++; $display("FAIL restart_data: got %0d want %0d", got, e); end
        end
      end
      if (done) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    tests++; if (!ok) begin fails++; $display("FAIL restart_timeout: done not seen in 100 cycles"); end
    tests++; if (n_acc - acc0 != 2) begin fails++; $display("FAIL restart_accepts: got %0d want 2", n_acc - acc0); end
    tests++; if (pops != 2) begin fails++; $display("FAIL restart_pops: got %0d want 2", pops); end
    tests++; if (n_done - d0 != 1) begin fails++; $display("FAIL restart_done_once: got %0d pulses want 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_single("dc", 25'sd4096, 25'sd4096, 25'sd4096, 25'sd4096, 25'sd47);
    test_single("tap4", 25'sd0, 25'sd0, 25'sd0, 25'sd100, 25'sd2);
    test_single("tap2", 25'sd0, 25'sd100, 25'sd0, 25'sd0, -25'sd1);
    test_stream();
    test_backpressure();
    test_reset_midframe();
    test_empty_and_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
